// File: rtl/zbuf_pkg.sv
// Definitions shared by the z-buffer pixel path: the handshake FSM states
// and default data widths used by pixel_fifo and contention_tree.
package zbuf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    RELEASE = 2'd2
  } hs_state_t;

  localparam int DEFAULT_PIXEL_WIDTH = 8;
  localparam int DEFAULT_LENGTH      = 8;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for pixel_fifo: one write port, one asynchronous
// read port. The data array has no reset.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_fifo.sv
// Pixel FIFO between the rasterizer and one contention_tree input: stores
// pixels and offers the head with a four-phase req/ack handshake.
module pixel_fifo
  import zbuf_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  parameter int LENGTH      = DEFAULT_LENGTH,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [PIXEL_WIDTH-1:0] pix_wr,
  output logic                   full,
  output logic                   overflow,
  output logic [PIXEL_WIDTH-1:0] pix_out,
  output logic [LENGTH-1:0]      fill,
  output logic                   req,
  input  logic                   ack
);

  localparam int PTR_W = $clog2(DEPTH);

  hs_state_t          state, state_next;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PIXEL_WIDTH-1:0] head_data;
  logic               accept, pop, load;
  logic               fill_nz;

  assign full    = (fill == LENGTH'(DEPTH));
  assign fill_nz = (fill != '0);
  assign accept  = rst_n && wr_en && !full;
  assign req     = (state == OFFER);

  fifo_mem #(
    .WIDTH (PIXEL_WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk    (clk),
    .we     (accept),
    .wr_addr(wr_ptr),
    .wr_data(pix_wr),
    .rd_addr(rd_ptr),
    .rd_data(head_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // fill always reflects post-pop occupancy here, so RELEASE can decide
  // between re-offering and idling without further bookkeeping.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (fill_nz) begin
          state_next = OFFER;
          load       = 1'b1;
        end
      end
      OFFER: begin
        if (ack) begin
          pop        = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack) begin
          if (fill_nz) begin
            state_next = OFFER;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      pix_out  <= '0;
    end else begin
      overflow <= wr_en && full;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   fill <= fill + LENGTH'(1);
        2'b01:   fill <= fill - LENGTH'(1);
        default: fill <= fill;
      endcase
      // The head is always a previously written entry when loaded, since
      // OFFER is only entered with a non-zero fill.
      if (load) pix_out <= head_data;
    end
  end

endmodule

// File: tb/tb_pixel_fifo.sv
// Directed bench for pixel_fifo: a scoreboard queue holds written pixels and
// a negedge monitor compares pix_out on every accepted handshake.
module tb_pixel_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] pix_wr;
  logic       full;
  logic       overflow;
  logic [7:0] pix_out;
  logic [7:0] fill;
  logic       req;
  logic       ack;

  int checks = 0;
  int errors = 0;
  int pop_count = 0;
  logic [7:0] exp_q [$];

  pixel_fifo #(.PIXEL_WIDTH(8), .LENGTH(8), .DEPTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .pix_wr  (pix_wr),
    .full    (full),
    .overflow(overflow),
    .pix_out (pix_out),
    .fill    (fill),
    .req     (req),
    .ack     (ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic a);
    wr_en  = w;
    pix_wr = d;
    ack    = a;
    tick();
  endtask

  task automatic writePixel(input logic [7:0] d);
    exp_q.push_back(d);
    applyStimulus(1'b1, d, 1'b0);
  endtask

  // One full four-phase transaction: wait for req, ack one cycle, release.
  task automatic handshake;
    int n = 0;
    wr_en = 1'b0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    checkOutput("req_wait", {31'd0, req}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("req_low_in_release", {31'd0, req}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && req && ack) begin
      pop_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pop_unexpected: got %0h, expected no pop", pix_out);
      end else begin
        checkOutput("pop_data", {24'd0, pix_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; pix_wr = 8'h00; ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checkOutput("rst_fill", {24'd0, fill}, 32'd0);
    checkOutput("rst_req", {31'd0, req}, 32'd0);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_pix_out", {24'd0, pix_out}, 32'd0);

    // Single write becomes an offer
    writePixel(8'hE2);
    wr_en = 1'b0;
    checkOutput("s1_fill", {24'd0, fill}, 32'd1);
    tick();
    checkOutput("s1_req", {31'd0, req}, 32'd1);
    checkOutput("s1_pix_out", {24'd0, pix_out}, 32'hE2);
    handshake();
    checkOutput("s1_fill_end", {24'd0, fill}, 32'd0);

    // Two writes drained in order
    writePixel(8'hA5);
    writePixel(8'h78);
    handshake();
    handshake();
    checkOutput("s2_fill_end", {24'd0, fill}, 32'd0);
    tick();
    checkOutput("s2_idle_req", {31'd0, req}, 32'd0);

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      writePixel(8'h10 + 8'(i));
      if (i == 14) checkOutput("s3_not_full_15", {31'd0, full}, 32'd0);
    end
    checkOutput("s3_full", {31'd0, full}, 32'd1);
    checkOutput("s3_fill16", {24'd0, fill}, 32'h10);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("s3_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("s3_fill_after_drop", {24'd0, fill}, 32'h10);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("s3_overflow_pulse", {31'd0, overflow}, 32'd0);

    // Drain to five entries, landing in OFFER
    for (int i = 0; i < 11; i++) handshake();
    checkOutput("s4_fill5", {24'd0, fill}, 32'd5);
    checkOutput("s4_offer", {31'd0, req}, 32'd1);
    checkOutput("s4_head", {24'd0, pix_out}, 32'h1B);
    exp_q.push_back(8'h3C);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    checkOutput("s4_fill_same", {24'd0, fill}, 32'd5);
    checkOutput("s4_release", {31'd0, req}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("s4_reoffer", {31'd0, req}, 32'd1);
    checkOutput("s4_next_head", {24'd0, pix_out}, 32'h1C);

    // ack held four cycles yields one pop
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("s5_req_held_low", {31'd0, req}, 32'd0);
    end
    checkOutput("s5_single_pop", {24'd0, fill}, 32'd4);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("s5_reoffer", {31'd0, req}, 32'd1);
    checkOutput("s5_head", {24'd0, pix_out}, 32'h1D);

    // Reset while in RELEASE with three entries left
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("s6_fill3", {24'd0, fill}, 32'd3);
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h99, 1'b1);
    checkOutput("s6_rst_fill", {24'd0, fill}, 32'd0);
    checkOutput("s6_rst_req", {31'd0, req}, 32'd0);
    checkOutput("s6_rst_pix_out", {24'd0, pix_out}, 32'd0);
    checkOutput("s6_rst_full", {31'd0, full}, 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("s6_idle_req", {31'd0, req}, 32'd0);
    checkOutput("s6_idle_fill", {24'd0, fill}, 32'd0);
    checkOutput("pop_total", pop_count, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_fifo.md
PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, the pixel word width.
REQ-002 SHALL have parameter LENGTH, default 8, the width of the fill count.
REQ-003 SHALL have parameter DEPTH, default 16, the storage entries; a power of 2 and at most 2**LENGTH-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port wr_en, input, 1 bit: write strobe from the rasterizer.
REQ-007 SHALL have port pix_wr, input, PIXEL_WIDTH bits: pixel to write.
REQ-008 SHALL have port full, output, 1 bit: high when fill equals DEPTH.
REQ-009 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-010 SHALL have port pix_out, output, PIXEL_WIDTH bits: pixel offered to the contention tree (pix_in_N).
REQ-011 SHALL have port fill, output, LENGTH bits: current entry count (fill_N).
REQ-012 SHALL have port req, output, 1 bit: offer request to the contention tree (req_N).
REQ-013 SHALL have port ack, input, 1 bit: grant/consume from the contention tree (ack_N).

Function
REQ-014 SHALL store pixels in a circular buffer of DEPTH entries, with write/read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a write on any cycle where wr_en=1 and full=0; the pixel becomes visible no earlier than the next cycle.
REQ-016 SHALL, on wr_en=1 with full=1, discard pix_wr, leave state unchanged, and pulse overflow high for exactly one cycle.
REQ-017 SHALL keep fill as a registered count of stored entries, including the entry currently offered; it is zero-extended to LENGTH bits.
REQ-018 SHALL, on a simultaneous accepted write and pop in one cycle, perform both and leave fill unchanged.
REQ-019 SHALL run a four-phase handshake FSM with states IDLE, OFFER and RELEASE.
REQ-020 SHALL, in IDLE (req=0): move to OFFER on the cycle after fill becomes non-zero.
REQ-021 SHALL, in OFFER (req=1): hold pix_out stable at the head entry; on ack=1, pop the head (fill decrements) and move to RELEASE.
REQ-022 SHALL, in RELEASE (req=0): wait for ack=0, then go to OFFER if fill is non-zero after the pop, otherwise to IDLE.
REQ-023 SHALL ignore ack while in IDLE; ack held high across RELEASE SHALL NOT cause a second pop.
REQ-024 SHALL pop at most one entry per four-phase transaction.
REQ-025 SHALL register pix_out and update it only on entry to OFFER.
REQ-026 SHALL make the full condition hold while the head is offered, i.e. the offered entry counts toward full.

Reset
REQ-027 SHALL, on clk edge with rst_n=0: clear the pointers and fill to 0, set the FSM to IDLE, and drive req=0, overflow=0, full=0 and pix_out=0.
REQ-028 SHALL, on reset mid-transaction (OFFER or RELEASE), abandon the transaction and discard all stored entries, with no pop reported.
REQ-029 SHALL ignore wr_en and ack during the reset cycle.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, OFFER, RELEASE) and the default PIXEL_WIDTH and LENGTH constants in shared package zbuf_pkg, also used by contention_tree.
REQ-031 SHALL use one sub-module, fifo_mem: a DEPTH x PIXEL_WIDTH single-write, single-read register array with no reset on its data.
REQ-032 SHALL be instantiable four times to feed contention_tree ports 1 to 4 directly.

Verification
REQ-033 Scenario: reset, then write E2 -> fill=1 the next cycle, req=1 within 2 cycles, pix_out=E2.
REQ-034 Scenario: write A5 and 78, then answer each req with ack high for 1 cycle followed by ack low -> pops return A5 then 78, req drops in RELEASE each time, and fill ends at 0 with the FSM in IDLE.
REQ-035 Scenario: 17 writes with DEPTH=16 and no ack -> full=1 after the 16th write, the 17th write pulses overflow, and fill=16 (0x10).
REQ-036 Scenario: fill=5 with the FSM in OFFER, then a write and ack in the same cycle -> fill stays 5, and after ack is released the next head is offered.
REQ-037 Scenario: ack held high for 4 cycles in OFFER -> exactly one pop, and req stays 0 until ack falls.
REQ-038 Scenario: rst_n=0 in RELEASE with fill=3 -> the next cycle shows fill=0, req=0, pix_out=00 and the FSM in IDLE.
